// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants for the 5-stage MIPS core control blocks:
//            register-address width, the hard-wired zero register, the
//            hazard controller state encoding and a register-match helper.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int MISS_CNT_W = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // Hazard controller states (2-bit, legacy-compatible encoding)
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_MISS   = 2'd2;

  // A source operand depends on a destination only if it is actually read
  // and is not r0 (r0 is constant, so it can never carry a hazard).
  function automatic logic src_match(input logic rd_en, input reg_addr_t src,
                                     input reg_addr_t dst);
    return rd_en && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter used for performance statistics.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset (count -> 0)
//            inc   - add one this cycle (ignored once all ones)
//            clear - synchronous clear, takes precedence over inc
//            count - current value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline interlock / stall controller for the 5-stage MIPS core.
//            Detects load-use and branch-operand hazards the forwarding path
//            cannot cover, holds the pipe during I/D-cache misses, flags
//            overlong misses and keeps saturating stall/bubble counters.
// Ports    : clk, rst_n              - clock, async active-low reset
//            RegAddrX/Y_ID, UseX/Y_ID - ID-stage source operands
//            Branch_ID, BranchTaken_ID- ID-stage branch compare / redirect
//            RegAddr_EX, RegWrite_EX, MemRead_EX - EX-stage destination
//            RegAddr_MEM, MemRead_MEM - MEM-stage destination (loads)
//            ICache_stall, DCache_stall - cache miss in progress
//            PC_en, IFID_en, Pipe_en  - register enables
//            IFID_flush, IDEX_flush   - wrong-path flush / bubble insert
//            Miss_timeout             - sticky overlong-miss flag
//            Stall_cnt, Bubble_cnt    - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] RegAddrX_ID,
  input  logic [REG_ADDR_W-1:0] RegAddrY_ID,
  input  logic                  UseX_ID,
  input  logic                  UseY_ID,
  input  logic                  Branch_ID,
  input  logic                  BranchTaken_ID,
  input  logic [REG_ADDR_W-1:0] RegAddr_EX,
  input  logic                  RegWrite_EX,
  input  logic                  MemRead_EX,
  input  logic [REG_ADDR_W-1:0] RegAddr_MEM,
  input  logic                  MemRead_MEM,
  input  logic                  ICache_stall,
  input  logic                  DCache_stall,
  output logic                  PC_en,
  output logic                  IFID_en,
  output logic                  IFID_flush,
  output logic                  IDEX_flush,
  output logic                  Pipe_en,
  output logic                  Miss_timeout,
  output logic [CNT_W-1:0]      Stall_cnt,
  output logic [CNT_W-1:0]      Bubble_cnt
);

  localparam logic [MISS_CNT_W-1:0] c_miss_limit = MISS_CNT_W'(MISS_TIMEOUT);

  logic                  w_hit_ex;
  logic                  w_hit_mem;
  logic                  w_lu;
  logic                  w_cs;
  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [MISS_CNT_W-1:0] r_miss_cnt;
  logic [MISS_CNT_W-1:0] w_miss_nxt;
  logic                  w_miss_inc;
  logic                  r_timeout;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign w_hit_ex  = RegWrite_EX &
                     (src_match(UseX_ID, RegAddrX_ID, RegAddr_EX) |
                      src_match(UseY_ID, RegAddrY_ID, RegAddr_EX));
  assign w_hit_mem = MemRead_MEM &
                     (src_match(UseX_ID, RegAddrX_ID, RegAddr_MEM) |
                      src_match(UseY_ID, RegAddrY_ID, RegAddr_MEM));

  // Loads can't forward into EX in time; branches compare in ID, so any
  // result still in EX, or a load still in MEM, is not ready for them.
  assign w_lu = (w_hit_ex & MemRead_EX) | (Branch_ID & w_hit_ex) |
                (Branch_ID & w_hit_mem);
  assign w_cs = ICache_stall | DCache_stall;

  // --------------------------------------------------------------------------
  // Enables / flushes: cache stall > interlock > taken branch > normal.
  // Held at free-run values during reset so the pipe starts cleanly.
  // --------------------------------------------------------------------------
  always_comb begin
    PC_en      = 1'b1;
    IFID_en    = 1'b1;
    Pipe_en    = 1'b1;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    if (rst_n) begin
      if (w_cs) begin
        PC_en   = 1'b0;
        IFID_en = 1'b0;
        Pipe_en = 1'b0;
      end else if (w_lu) begin
        // Branch outcome is untrusted while its operands are pending
        PC_en      = 1'b0;
        IFID_en    = 1'b0;
        IDEX_flush = 1'b1;
      end else if (BranchTaken_ID) begin
        IFID_flush = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control state machine
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN: begin
        if (w_cs)      w_state_nxt = ST_MISS;
        else if (w_lu) w_state_nxt = ST_BUBBLE;
        else           w_state_nxt = ST_RUN;
      end
      ST_BUBBLE: w_state_nxt = w_cs ? ST_MISS : ST_RUN;
      ST_MISS:   w_state_nxt = w_cs ? ST_MISS : ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // Miss length counts MISS cycles after the entry cycle; it saturates so a
  // very long miss cannot wrap back past the limit.
  assign w_miss_inc = (r_state == ST_MISS) & w_cs;
  assign w_miss_nxt = (r_miss_cnt == '1) ? r_miss_cnt
                                         : r_miss_cnt + MISS_CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_miss_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cs && (r_state != ST_MISS)) begin
        r_miss_cnt <= '0;
      end else if (w_miss_inc) begin
        r_miss_cnt <= w_miss_nxt;
      end
      // Sticky diagnostic only; stalling continues regardless
      if (w_miss_inc && (w_miss_nxt == c_miss_limit)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign Miss_timeout = r_timeout;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_cs),
    .clear (1'b0),
    .count (Stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IDEX_flush),
    .clear (1'b0),
    .count (Bubble_cnt)
  );

endmodule
`default_nettype wire
